ttc_count_lite: RTL

Timer counter core for one TTC channel. It consumes the registered clock-control byte and the count-enable strobe that the channel's counter-reset/clock-control block produces. It prescales the selected count source, runs a 16-bit up/down counter in overflow or interval mode, and raises single-cycle interval, match and overflow event pulses. These pulses go to the channel's interrupt register block, which sits downstream.

---
 rtl/ttc_count_lite.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ttc_count_lite.sv
// ttc_count_lite: prescaled 16-bit up/down timer counter for one TTC channel.
// Produces single-cycle interval, match and overflow pulses for the interrupt block.
module ttc_count_lite #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PRE_W = 16
) (
    input  logic             pclk,
    input  logic             p_reset,
    input  logic [6:0]       clk_ctrl_reg,
    input  logic             count_en,
    input  logic             restart,
    input  logic             count_dis,
    input  logic             interval_mode,
    input  logic             decrement,
    input  logic             match_en,
    input  logic [CNT_W-1:0] interval_val,
    input  logic [CNT_W-1:0] match_val,
    input  logic             ext_clk,
    output logic [CNT_W-1:0] counter_val,
    output logic             interval_pulse,
    output logic             match_pulse,
    output logic             overflow_pulse
);

    localparam logic [CNT_W-1:0] AllOnes = {CNT_W{1'b1}};

    logic             pre_en;
    logic [3:0]       pre_n;
    logic             ext_sel;
    logic             ext_fall;

    logic             ext_sync1_q;
    logic             ext_sync2_q;
    logic             ext_dly_q;

    logic [PRE_W-1:0] prescale_cnt_q;
    logic [PRE_W-1:0] prescale_cnt_d;
    logic [PRE_W-1:0] pre_limit;
    logic             pre_hit;

    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] counter_d;
    logic [CNT_W-1:0] restart_val;
    logic             interval_pulse_q;
    logic             interval_pulse_d;
    logic             match_pulse_q;
    logic             match_pulse_d;
    logic             overflow_pulse_q;
    logic             overflow_pulse_d;

    logic             src_evt;
    logic             count_on;
    logic             restart_cond;
    logic             tick;

    assign pre_en   = clk_ctrl_reg[0];
    assign pre_n    = clk_ctrl_reg[4:1];
    assign ext_sel  = clk_ctrl_reg[5];
    assign ext_fall = clk_ctrl_reg[6];

    // Synchronize the external count source and keep one extra stage for edge detection.
    always_ff @(posedge pclk) begin
        if (p_reset) begin
            ext_sync1_q <= 1'b0;
            ext_sync2_q <= 1'b0;
            ext_dly_q   <= 1'b0;
        end else begin
            ext_sync1_q <= ext_clk;
            ext_sync2_q <= ext_sync1_q;
            ext_dly_q   <= ext_sync2_q;
        end
    end

    // Select the count source and derive the enable, restart and tick qualifiers.
    always_comb begin
        if (!ext_sel) begin
            src_evt = 1'b1;
        end else if (ext_fall) begin
            src_evt = ext_dly_q & ~ext_sync2_q;
        end else begin
            src_evt = ~ext_dly_q & ext_sync2_q;
        end
        // Terminal prescale count is 2^(N+1) - 1: the low N+1 bits set.
        for (int i = 0; i < int'(PRE_W); i++) begin
            pre_limit[i] = (i <= int'(pre_n));
        end
        pre_hit      = (prescale_cnt_q == pre_limit);
        count_on     = count_en & ~count_dis;
        // Restart only acts in the first cycle of the handshake, while count_en is low.
        restart_cond = restart & ~count_en;
        tick         = count_on & src_evt & (~pre_en | pre_hit);
    end

    // Prescaler next state: wraps after the terminal count, cleared on restart.
    always_comb begin
        prescale_cnt_d = prescale_cnt_q;
        if (restart_cond) begin
            prescale_cnt_d = '0;
        end else if (count_on && src_evt) begin
            if (!pre_en || pre_hit) begin
                prescale_cnt_d = '0;
            end else begin
                prescale_cnt_d = prescale_cnt_q + PRE_W'(1);
            end
        end
    end

    // Counter next state and event pulses for the coming edge.
    always_comb begin
        counter_d        = counter_q;
        interval_pulse_d = 1'b0;
        match_pulse_d    = 1'b0;
        overflow_pulse_d = 1'b0;
        if (!decrement) begin
            restart_val = '0;
        end else if (interval_mode) begin
            restart_val = interval_val;
        end else begin
            restart_val = AllOnes;
        end

        if (restart_cond) begin
            counter_d = restart_val;
        end else if (tick) begin
            if (!decrement) begin
                if (interval_mode && (counter_q == interval_val)) begin
                    counter_d        = '0;
                    interval_pulse_d = 1'b1;
                end else if (counter_q == AllOnes) begin
                    // Also reached in interval mode when the count is above the limit.
                    counter_d        = '0;
                    overflow_pulse_d = 1'b1;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end else begin
                if (counter_q == '0) begin
                    if (interval_mode) begin
                        counter_d        = interval_val;
                        interval_pulse_d = 1'b1;
                    end else begin
                        counter_d        = AllOnes;
                        overflow_pulse_d = 1'b1;
                    end
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end
            match_pulse_d = match_en & (counter_d == match_val);
        end
    end

    // Prescaler, counter and registered pulses.
    always_ff @(posedge pclk) begin
        if (p_reset) begin
            prescale_cnt_q   <= '0;
            counter_q        <= '0;
            interval_pulse_q <= 1'b0;
            match_pulse_q    <= 1'b0;
            overflow_pulse_q <= 1'b0;
        end else begin
            prescale_cnt_q   <= prescale_cnt_d;
            counter_q        <= counter_d;
            interval_pulse_q <= interval_pulse_d;
            match_pulse_q    <= match_pulse_d;
            overflow_pulse_q <= overflow_pulse_d;
        end
    end

    assign counter_val    = counter_q;
    assign interval_pulse = interval_pulse_q;
    assign match_pulse    = match_pulse_q;
    assign overflow_pulse = overflow_pulse_q;

endmodule
